// File: rtl/mul16_pkg.sv
// Shared definitions for the 16x16 bit-heap multiplier front end.
// Column K of the AND array holds every a[i]&b[j] with i+j == K. The columns
// are packed LSB-first into one flat vector of OP_W*OP_W bits, and col_off()
// gives the starting bit of column K within that vector.
package mul16_pkg;

  localparam int OP_W    = 16;
  localparam int NCOL    = 2 * OP_W - 1;  // 31 partial-product columns
  localparam int NDST    = 2 * OP_W + 1;  // 33 compressor result bits
  localparam int PP_BITS = OP_W * OP_W;   // total partial-product bits

  typedef logic [2*OP_W-1:0] prod_t;

  // Number of partial-product bits in column k.
  function automatic int col_width(input int k);
    return (k < OP_W) ? k + 1 : NCOL - k;
  endfunction

  // Lowest multiplicand index that contributes to column k.
  function automatic int col_lo(input int k);
    return (k > OP_W - 1) ? k - (OP_W - 1) : 0;
  endfunction

  // Bit offset of column k inside the flat partial-product vector.
  function automatic int col_off(input int k);
    int off;
    off = 0;
    for (int j = 0; j < k; j++) off += col_width(j);
    return off;
  endfunction

endpackage

// File: rtl/mul16_pp_feeder_if.sv
// Operand and result handshake bundle of mul16_pp_feeder.
//   in_valid/in_ready/in_a/in_b : operand pair, valid/ready
//   out_valid/out_ready/out_p   : product stream from the result FIFO head
//   ovf_err                     : sticky compressor-overflow flag
// The master modport is the environment. The slave modport is the feeder.
interface mul16_pp_feeder_if;
  import mul16_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_a;
  logic [OP_W-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  prod_t           out_p;
  logic            ovf_err;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p, ovf_err
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p, ovf_err
  );

endinterface

// File: rtl/mul16_result_fifo.sv
// Synchronous FIFO that holds compressor results until the consumer takes them.
// Any DEPTH >= 1 is supported, and the pointers wrap modulo DEPTH.
//   clk, rst_n : clock and async active-low reset
//   push/data  : write push_data at the edge
//   pop        : drop the head at the edge; ignored when empty
//   head       : current head entry, or zero when empty
//   count      : number of stored entries
//   empty      : count == 0
module mul16_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             full;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CNT_W'(DEPTH));
  assign do_pop = pop && !empty;
  assign count  = cnt_q;
  assign head   = empty ? '0 : mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset. The pointers and count decide which
  // entries are meaningful, and head is masked to zero when the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // The upstream credit check keeps in-flight + stored <= DEPTH, so this
  // assertion can fire only if that bookkeeping is broken.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && full));
  end

endmodule

// File: rtl/mul16_pp_feeder.sv
// Front end of the 16x16 bit-heap multiplier.
// It accepts operand pairs and registers the AND-array columns src0..src30 for
// the compressor. It then captures dst0..dst32 COMP_LATENCY+1 edges after each
// accept into a result FIFO. The compressor cannot stall, so operands are
// accepted only when a FIFO slot is already reserved for the result.
//   clk, rst_n   : clock and async active-low reset
//   bus (slave)  : operand/result handshake and ovf_err
//   srcK         : partial-product column K (width col_width(K))
//   dstK         : compressor result bit K; dst32 set means overflow
module mul16_pp_feeder
  import mul16_pkg::*;
#(
  parameter int COMP_LATENCY = 3,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic rst_n,
  mul16_pp_feeder_if.slave bus,
  output logic        src0,
  output logic [1:0]  src1,
  output logic [2:0]  src2,
  output logic [3:0]  src3,
  output logic [4:0]  src4,
  output logic [5:0]  src5,
  output logic [6:0]  src6,
  output logic [7:0]  src7,
  output logic [8:0]  src8,
  output logic [9:0]  src9,
  output logic [10:0] src10,
  output logic [11:0] src11,
  output logic [12:0] src12,
  output logic [13:0] src13,
  output logic [14:0] src14,
  output logic [15:0] src15,
  output logic [14:0] src16,
  output logic [13:0] src17,
  output logic [12:0] src18,
  output logic [11:0] src19,
  output logic [10:0] src20,
  output logic [9:0]  src21,
  output logic [8:0]  src22,
  output logic [7:0]  src23,
  output logic [6:0]  src24,
  output logic [5:0]  src25,
  output logic [4:0]  src26,
  output logic [3:0]  src27,
  output logic [2:0]  src28,
  output logic [1:0]  src29,
  output logic        src30,
  input  logic dst0,  dst1,  dst2,  dst3,  dst4,  dst5,  dst6,  dst7,
  input  logic dst8,  dst9,  dst10, dst11, dst12, dst13, dst14, dst15,
  input  logic dst16, dst17, dst18, dst19, dst20, dst21, dst22, dst23,
  input  logic dst24, dst25, dst26, dst27, dst28, dst29, dst30, dst31,
  input  logic dst32
);

  logic [PP_BITS-1:0]    pp_d;
  logic [PP_BITS-1:0]    pp_q;
  logic [COMP_LATENCY:0] vpipe;
  logic [CNT_W-1:0]      in_flight;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        credit_used;
  logic                  accept;
  logic                  capture;
  logic                  pop;
  logic                  fifo_empty;
  prod_t                 dst_bus;
  prod_t                 fifo_head;

  // AND-array columns: bit n of column k is a[lo+n] & b[k-lo-n].
  for (genvar k = 0; k < NCOL; k++) begin : g_col
    for (genvar n = 0; n < col_width(k); n++) begin : g_bit
      assign pp_d[col_off(k) + n] = bus.in_a[col_lo(k) + n] & bus.in_b[k - col_lo(k) - n];
    end
  end

  assign accept  = bus.in_valid && bus.in_ready;
  assign capture = vpipe[COMP_LATENCY];
  assign pop     = bus.out_valid && bus.out_ready;

  // A slot is reserved for every accepted operand until its result is
  // captured, so the FIFO can never be full at a capture edge.
  assign credit_used  = {1'b0, in_flight} + {1'b0, fifo_count};
  assign bus.in_ready = rst_n && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));

  // Columns are loaded only on accept. The compressor tolerates stale inputs
  // because only valid-pipe tails are captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pp_q <= '0;
    else if (accept) pp_q <= pp_d;
  end

  // The valid pipe advances unconditionally, in step with the free-running
  // compressor pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= accept;
      for (int i = 1; i <= COMP_LATENCY; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight <= '0;
    end else begin
      case ({accept, capture})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.ovf_err <= 1'b0;
    else if (capture && dst32) bus.ovf_err <= 1'b1;
  end

  assign dst_bus = {dst31, dst30, dst29, dst28, dst27, dst26, dst25, dst24,
                    dst23, dst22, dst21, dst20, dst19, dst18, dst17, dst16,
                    dst15, dst14, dst13, dst12, dst11, dst10, dst9,  dst8,
                    dst7,  dst6,  dst5,  dst4,  dst3,  dst2,  dst1,  dst0};

  mul16_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(prod_t)),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (dst_bus),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_p     = fifo_head;

  assign src0  = pp_q[col_off(0)  +: col_width(0)];
  assign src1  = pp_q[col_off(1)  +: col_width(1)];
  assign src2  = pp_q[col_off(2)  +: col_width(2)];
  assign src3  = pp_q[col_off(3)  +: col_width(3)];
  assign src4  = pp_q[col_off(4)  +: col_width(4)];
  assign src5  = pp_q[col_off(5)  +: col_width(5)];
  assign src6  = pp_q[col_off(6)  +: col_width(6)];
  assign src7  = pp_q[col_off(7)  +: col_width(7)];
  assign src8  = pp_q[col_off(8)  +: col_width(8)];
  assign src9  = pp_q[col_off(9)  +: col_width(9)];
  assign src10 = pp_q[col_off(10) +: col_width(10)];
  assign src11 = pp_q[col_off(11) +: col_width(11)];
  assign src12 = pp_q[col_off(12) +: col_width(12)];
  assign src13 = pp_q[col_off(13) +: col_width(13)];
  assign src14 = pp_q[col_off(14) +: col_width(14)];
  assign src15 = pp_q[col_off(15) +: col_width(15)];
  assign src16 = pp_q[col_off(16) +: col_width(16)];
  assign src17 = pp_q[col_off(17) +: col_width(17)];
  assign src18 = pp_q[col_off(18) +: col_width(18)];
  assign src19 = pp_q[col_off(19) +: col_width(19)];
  assign src20 = pp_q[col_off(20) +: col_width(20)];
  assign src21 = pp_q[col_off(21) +: col_width(21)];
  assign src22 = pp_q[col_off(22) +: col_width(22)];
  assign src23 = pp_q[col_off(23) +: col_width(23)];
  assign src24 = pp_q[col_off(24) +: col_width(24)];
  assign src25 = pp_q[col_off(25) +: col_width(25)];
  assign src26 = pp_q[col_off(26) +: col_width(26)];
  assign src27 = pp_q[col_off(27) +: col_width(27)];
  assign src28 = pp_q[col_off(28) +: col_width(28)];
  assign src29 = pp_q[col_off(29) +: col_width(29)];
  assign src30 = pp_q[col_off(30) +: col_width(30)];

endmodule

// File: doc/mul16_pp_feeder.md
Name: mul16_pp_feeder

Overview:
Upstream stage of the 16x16 bit-heap multiplier. It accepts unsigned operand pairs over a valid/ready handshake and registers the AND-array partial-product columns src0..src30 that drive the compressor. It then captures the compressor's column outputs dst0..dst32 after a fixed latency into a credit-protected result FIFO. The compressor cannot stall, so this block owns all flow control around it.

Parameters:
- COMP_LATENCY, 3, register stages inside the compressor from src to dst (0 = combinational).
- FIFO_DEPTH, 8, result FIFO entries; must be >= COMP_LATENCY+2.
- CNT_W, 4, width of the in-flight and occupancy counters; must satisfy 2**CNT_W > FIFO_DEPTH.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  pair accepted at the edge where in_valid && in_ready.
- in_a  in  16  multiplicand, unsigned.
- in_b  in  16  multiplier, unsigned.
- srcK (K=0..30)  out  K<16 ? K+1 : 31-K  partial-product column K, to compressor srcK.
- dstK (K=0..32)  in  1  compressor result bit K.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes head at edge where out_valid && out_ready.
- out_p  out  32  product, FIFO head.
- ovf_err  out  1  sticky; a capture saw dst32=1.

Behaviour:
- Reset (async assert, sync release): all srcK=0, valid pipe cleared, in-flight=0, FIFO empty, out_valid=0, out_p=0, ovf_err=0, in_ready=0 while rst_n low.
- Column mapping: lo=max(0,K-15); bit n of srcK = in_a[lo+n] & in_b[K-lo-n].
- srcK registers load only on accept. Otherwise they hold their last value. There is no bubble zeroing.
- Valid pipe: a 1-bit shift register of length COMP_LATENCY+1. Stage 0 is set on accept, and it advances every cycle unconditionally.
- Capture: when the pipe tail is 1, {dst31..dst0} is pushed into the FIFO at that edge. If dst32=1 at that edge, ovf_err is set.
- Latency: for an accept at edge t, capture happens at edge t+1+COMP_LATENCY. out_valid rises in the cycle after that edge if the FIFO was empty (default: 4 cycles after the accept edge).
- Credit rule: in_ready = rst_n && (in_flight + fifo_count) < FIFO_DEPTH, combinational from registers only. It does not depend on in_valid or out_ready in the same cycle.
- in_flight bookkeeping: +1 on accept, -1 on capture. Simultaneous +1/-1 leaves it unchanged.
- fifo_count bookkeeping: +1 on capture, -1 on pop. Simultaneous push/pop leaves it unchanged, and the order of results is preserved.
- Push into a full FIFO is impossible by construction. An assertion flags it if it happens.
- FIFO pointers wrap modulo FIFO_DEPTH. Any depth is legal, not only powers of two.
- out_p equals the FIFO head. It is stable while out_valid && !out_ready.
- Reset mid-operation: in-flight and buffered results are discarded. No out_valid pulse occurs after reset for pre-reset operands.
- Results are in strict input order. Throughput is 1 result/cycle when out_ready is held high.

Decomposition:
- Package mul16_pkg:
  - OP_W=16, NCOL=31, NDST=33.
  - Function col_width(K).
  - Function col_lo(K).
  - Typedef prod_t (32-bit).
- One sub-module: mul16_result_fifo, a synchronous FIFO with push/pop/count/head, parameterised by depth and width, with async active-low reset.
- Column generation stays as generate loops in the top.

Test Plan:
- The bench uses a behavioural compressor model: a COMP_LATENCY-stage register pipeline of sum(srcK bits)<<K.
- Max operands: a=0xFFFF, b=0xFFFF, single accept -> out_valid 4 cycles later, out_p=0x FFFE0001, ovf_err=0.
- Zero and identity: a=0x0000, b=0x1234, then a=0x0001, b=0xBEEF, back-to-back -> out_p=0x00000000 then 0x0000BEEF, on consecutive cycles.
- Backpressure: out_ready=0, in_valid held high with a=i+1, b=3 -> exactly 8 accepts, then in_ready=0. After raising out_ready, products arrive in order 3,6,...,24 with no loss or duplication.
- Simultaneous events: with FIFO at 7 entries, do a pop and a capture in the same edge -> count stays 7, and in_ready follows the credit formula exactly.
- Reset mid-flight: two accepts, then rst_n low for 1 cycle 2 cycles later -> outputs go to reset values immediately, and no out_valid appears for 10 cycles afterward.
- Overflow flag: the model forces dst32=1 on one capture -> ovf_err=1 from the next cycle and stays set until rst_n is asserted.
